// File: rtl/chorus_pkg.sv
// chorus_pkg: shared constants and FSM encoding for the chorus LFO.
//   PHASE_W      phase accumulator width
//   DELAY_W      delay-tap select width (output range 0..2^DELAY_W-1)
//   RATE_W       width of the per-sample phase increment input
//   TRI_W        width of the folded triangle value
//   RESET_DELAY  delay_out and center value after reset
package chorus_pkg;

  localparam int PHASE_W = 24;
  localparam int DELAY_W = 6;
  localparam int RATE_W  = 16;
  localparam int TRI_W   = 8;

  localparam logic [DELAY_W-1:0] RESET_DELAY = 6'd32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC   = 3'd1,
    SCALE = 3'd2,
    SAT   = 3'd3,
    OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/lfo_triangle.sv
// lfo_triangle: phase accumulator with triangle fold.
//   clk      system clock
//   reset    synchronous active-high reset (phase returns to 0)
//   step     advance the phase by rate this cycle
//   rate     phase increment, zero-extended to PHASE_W
//   phase    accumulator value (wraps naturally mod 2^PHASE_W)
//   tri_val  unsigned triangle derived from the current phase
module lfo_triangle
  import chorus_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic [RATE_W-1:0]  rate,
  output logic [PHASE_W-1:0] phase,
  output logic [TRI_W-1:0]   tri_val
);

  logic [TRI_W-1:0] fold;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else if (step) begin
      phase <= phase + {{(PHASE_W-RATE_W){1'b0}}, rate};
    end
  end

  // The top phase bit selects the rising or falling half; the next TRI_W
  // bits are the position within that half, inverted on the way down.
  assign fold    = phase[PHASE_W-2 -: TRI_W];
  assign tri_val = phase[PHASE_W-1] ? ~fold : fold;

endmodule

// File: rtl/chorus_lfo.sv
// chorus_lfo: triangle LFO scaled by depth around center, clamped and
// slew-limited into a delay-tap select for the chorus delay line.
//   clk         system clock
//   reset       synchronous active-high reset
//   clk_enable  one-cycle audio sample strobe
//   cfg_load    one-cycle pulse capturing rate/depth/center
//   rate        phase increment per sample
//   depth       peak-to-peak modulation span
//   center      modulation midpoint
//   ce_out      one-cycle strobe: delay_out updated this cycle
//   delay_out   delay-tap select
//   overrun     sticky: a strobe arrived while busy
//   state_dbg   current FSM state
//   phase_dbg   current LFO phase
//
// Strobe semantics: clk_enable is a fire-and-forget pulse with no ready
// back-pressure. It is accepted only when the FSM is IDLE; any strobe seen
// in another state (including the OUT cycle) is discarded and sets overrun.
// ce_out pulses for exactly one cycle four cycles after an accepted strobe,
// and delay_out only ever changes in that same cycle.
module chorus_lfo
  import chorus_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic               cfg_load,
  input  logic [RATE_W-1:0]  rate,
  input  logic [DELAY_W-1:0] depth,
  input  logic [DELAY_W-1:0] center,
  output logic               ce_out,
  output logic [DELAY_W-1:0] delay_out,
  output logic               overrun,
  output state_t             state_dbg,
  output logic [PHASE_W-1:0] phase_dbg
);

  state_t state;

  logic [RATE_W-1:0]  rate_r;
  logic [DELAY_W-1:0] depth_r;
  logic [DELAY_W-1:0] center_r;

  // Config captured while busy, applied on the first IDLE cycle.
  logic               pend_valid;
  logic [RATE_W-1:0]  pend_rate;
  logic [DELAY_W-1:0] pend_depth;
  logic [DELAY_W-1:0] pend_center;

  logic [DELAY_W-1:0] offs_r;
  logic [DELAY_W-1:0] target_r;

  logic [PHASE_W-1:0]         phase;
  logic [TRI_W-1:0]           tri_val;
  logic [TRI_W+DELAY_W-1:0]   prod;
  logic [DELAY_W-1:0]         offs_next;
  logic signed [DELAY_W+1:0]  target_sum;
  logic [DELAY_W-1:0]         target_clamped;

  lfo_triangle u_tri (
    .clk     (clk),
    .reset   (reset),
    .step    (state == ACC),
    .rate    (rate_r),
    .phase   (phase),
    .tri_val (tri_val)
  );

  // offs = (tri * depth) >> TRI_W, which stays within 0..depth.
  assign prod      = {{DELAY_W{1'b0}}, tri_val} * {{TRI_W{1'b0}}, depth_r};
  assign offs_next = DELAY_W'(prod >> TRI_W);

  // Two extra bits: one for the negative low swing, one for overshoot
  // above the top of the delay range.
  assign target_sum = $signed({2'b00, center_r})
                    + $signed({2'b00, offs_r})
                    - $signed({3'b000, depth_r[DELAY_W-1:1]});

  always_comb begin
    target_clamped = target_sum[DELAY_W-1:0];
    if (target_sum[DELAY_W+1]) begin
      target_clamped = '0;
    end else if (target_sum[DELAY_W]) begin
      target_clamped = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rate_r      <= '0;
      depth_r     <= '0;
      center_r    <= RESET_DELAY;
      pend_valid  <= 1'b0;
      pend_rate   <= '0;
      pend_depth  <= '0;
      pend_center <= '0;
      offs_r      <= '0;
      target_r    <= RESET_DELAY;
      delay_out   <= RESET_DELAY;
      ce_out      <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      ce_out <= 1'b0;

      case (state)
        IDLE: begin
          if (clk_enable) state <= ACC;
        end
        ACC: begin
          state <= SCALE;
        end
        SCALE: begin
          offs_r <= offs_next;
          state  <= SAT;
        end
        SAT: begin
          target_r <= target_clamped;
          state    <= OUT;
        end
        OUT: begin
          if (target_r > delay_out) begin
            delay_out <= delay_out + 1'b1;
          end else if (target_r < delay_out) begin
            delay_out <= delay_out - 1'b1;
          end
          ce_out <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (state != IDLE && clk_enable) overrun <= 1'b1;

      // Config only changes between computations; a direct load in IDLE
      // supersedes anything still pending.
      if (state == IDLE) begin
        if (cfg_load) begin
          rate_r     <= rate;
          depth_r    <= depth;
          center_r   <= center;
          pend_valid <= 1'b0;
          overrun    <= 1'b0;
        end else if (pend_valid) begin
          rate_r     <= pend_rate;
          depth_r    <= pend_depth;
          center_r   <= pend_center;
          pend_valid <= 1'b0;
          overrun    <= 1'b0;
        end
      end else if (cfg_load) begin
        pend_rate   <= rate;
        pend_depth  <= depth;
        pend_center <= center;
        pend_valid  <= 1'b1;
      end
    end
  end

  assign state_dbg = state;
  assign phase_dbg = phase;

endmodule

// File: doc/chorus_lfo.md
# chorus_lfo

Modulation source for the chorus effect in the audio loopback path. On each audio sample strobe it advances a triangle LFO and scales it by a depth around a center value. It then slew-limits the result into the 6-bit delay-tap select that the chorus stage consumes alongside the sample, and emits an aligned strobe. It sits directly upstream of the chorus delay line, clocked and strobed with it.

## Interface
- PHASE_W, 24: phase accumulator width.
- DELAY_W, 6: delay-select width; output range 0..2^DELAY_W-1.
- RESET_DELAY, 32: delay_out and center value after reset.

- clk  in  1  system clock; one clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- clk_enable  in  1  one-cycle audio sample strobe.
- cfg_load  in  1  one-cycle pulse; capture rate/depth/center.
- rate  in  16  phase increment per sample, zero-extended to PHASE_W.
- depth  in  DELAY_W  peak-to-peak modulation span.
- center  in  DELAY_W  modulation midpoint.
- ce_out  out  1  one-cycle strobe: delay_out updated this cycle.
- delay_out  out  DELAY_W  delay-tap select for the chorus stage.
- overrun  out  1  sticky: a strobe arrived while busy.

## Operation
- FSM states: IDLE, ACC, SCALE, SAT, OUT.
  - IDLE→ACC on clk_enable; ACC→SCALE→SAT→OUT→IDLE unconditionally.
- ACC: phase <= phase + rate_r, mod 2^PHASE_W, with natural wrap.
  - tri (8-bit unsigned) is computed from the new phase.
  - If phase[MSB]=0: tri = phase[MSB-1 -: 8]; else tri = ~phase[MSB-1 -: 8].
- SCALE: offs = (tri * depth_r) >> 8, range 0..depth_r.
- SAT: compute target = center_r + offs − (depth_r >> 1) in signed DELAY_W+2 bits.
  - Clamp target to [0, 2^DELAY_W−1].
- OUT: slew-limit, at most one step per sample.
  - target > delay_out: delay_out+1.
  - target < delay_out: delay_out−1.
  - Otherwise delay_out holds.
  - ce_out=1 for this cycle only.
- Config:
  - cfg_load in IDLE: rate_r/depth_r/center_r load on the next edge and overrun clears.
  - cfg_load while not IDLE: values captured into a pending register and applied on the first IDLE cycle. The last pulse wins.
  - Config is never changed mid-computation.
- rate=0 freezes phase; delay_out still slews toward the frozen target.
- clk_enable while not IDLE: the strobe is dropped, phase is not advanced, and overrun is set.
  - overrun clears only on reset or an applied cfg_load.
- clk_enable coinciding with OUT→IDLE is also dropped; the FSM is not yet IDLE.

## Timing
- Strobe sampled at edge n.
  - ce_out high and the new delay_out visible in the cycle following edge n+4.
  - Latency 4 cycles.
- Minimum strobe spacing for no overrun is 5 cycles. The audio rate leaves more than 100 cycles of spacing.
- delay_out is stable between ce_out pulses.
- Reset values:
  - phase=0, delay_out=RESET_DELAY, center_r=RESET_DELAY.
  - rate_r=0, depth_r=0, ce_out=0, overrun=0.
  - FSM=IDLE, pending cleared.
- Reset asserted mid-operation aborts the computation. No ce_out follows, and outputs hold reset values from the next cycle.

## Structure
- Package chorus_pkg:
  - DELAY_W, PHASE_W, RESET_DELAY constants.
  - FSM state encoding.
  - The tri width (8) constant.
- Sub-module lfo_triangle: phase accumulator plus triangle fold. Inputs: step enable and rate; outputs: phase and tri.
- Scaling, saturation, slew and config hold stay in chorus_lfo.

## Test plan
1. Reset asserted for 2 cycles → delay_out=32, ce_out=0, overrun=0. No ce_out is produced without a strobe.
2. Config and slew:
   - Stimulus: cfg_load with rate=0, depth=0, center=20, then strobes every 200 cycles.
   - Response: delay_out steps 31,30,…,20, one per strobe, then holds 20.
   - Each ce_out occurs exactly 4 cycles after its strobe.
3. Full sweep:
   - Stimulus: center=32, depth=40, rate=0x0100, 2^16+ strobes.
   - Response: delay_out stays within 12..51 and never changes by more than 1 per ce_out.
   - Response: the sweep covers both extremes, with a period of 2^24/0x100 = 65536 strobes.
4. Saturation:
   - center=2, depth=63, rate=0x4000: the low swing clamps and delay_out reaches 0, never wrapping to 63.
   - center=60, depth=63: delay_out reaches 63, never wrapping to 0.
5. Overrun:
   - Stimulus: strobes 2 cycles apart.
   - Response: only one ce_out, phase advances by rate once, overrun=1.
   - A subsequent cfg_load in IDLE clears overrun.
6. Pending config and mid-operation reset:
   - cfg_load one cycle after a strobe: the in-flight update uses the old depth, and the next strobe uses the new depth.
   - reset in SCALE: no ce_out, and delay_out=32 on the next cycle.
